// File: rtl/dest_scoreboard.sv
// dest_scoreboard
// Issue-stage destination scoreboard for the pipelined MIPS core.
// It decodes the instruction offered at issue and tracks in-flight
// destination registers in a DEPTH-slot shift pipeline. It stalls issue on
// a read-after-write hazard, or during the branch shadow that follows a
// control instruction. It also reports the register that retires each cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears all tracking state
//   flush        clears all slots and the branch shadow at the next edge
//   issue_valid  issue_instr is a real instruction this cycle
//   issue_instr  32-bit instruction word offered for issue
//   stall        combinational; offered instruction is not accepted
//   accept       combinational; issue_valid & ~stall
//   busy_mask    bit r set when any valid slot holds destination r
//   inflight     number of valid slots
//   wb_valid     the oldest slot held a valid destination and just retired
//   wb_dest      register that retired, 0 when wb_valid is low
//   illegal      combinational; issue_valid with an undecodable opcode
//
// Parameters:
//   DEPTH      number of in-flight slots (1..8); slot 0 is the youngest
//   FWD        0: stall on any source match; 1: stall only on load-use
//   BR_SHADOW  forced stall cycles after an accepted branch/jump (0..7)

module dest_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int FWD       = 0,
    parameter int BR_SHADOW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [31:0] issue_instr,
    output logic        stall,
    output logic        accept,
    output logic [31:0] busy_mask,
    output logic [3:0]  inflight,
    output logic        wb_valid,
    output logic [4:0]  wb_dest,
    output logic        illegal
);

    localparam logic [2:0] SHADOW_LOAD = 3'(BR_SHADOW);

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_load;
    logic [4:0]       slot_dest [DEPTH];
    logic [2:0]       shadow_cnt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dec_dest;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       dec_load;
    logic       dec_branch;
    logic       dec_illegal;
    logic       hazard;

    assign opcode = issue_instr[31:26];
    assign rs     = issue_instr[25:21];
    assign rt     = issue_instr[20:16];
    assign rd     = issue_instr[15:11];

    // Instruction decode. An unused source is reported as register 0, and
    // register 0 never matches a slot, so unused sources cannot cause a hazard.
    always_comb begin
        dec_dest    = 5'd0;
        src_a       = 5'd0;
        src_b       = 5'd0;
        dec_load    = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            6'b000000: begin dec_dest = rd; src_a = rs; src_b = rt; end
            6'b001000: begin dec_dest = rt; src_a = rs; end
            6'b100011: begin dec_dest = rt; src_a = rs; dec_load = 1'b1; end
            6'b101011: begin src_a = rs; src_b = rt; end
            6'b000010: begin dec_branch = 1'b1; end
            6'b000100: begin src_a = rs; src_b = rt; dec_branch = 1'b1; end
            default:   begin dec_illegal = 1'b1; end
        endcase
    end

    // Hazard detection. Without forwarding, any in-flight producer of a
    // source blocks issue. With forwarding, only a load in the youngest slot
    // blocks issue, because its data is not yet available to forward.
    always_comb begin
        hazard = 1'b0;
        if (FWD == 0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (slot_valid[k] &&
                    ((src_a != 5'd0 && src_a == slot_dest[k]) ||
                     (src_b != 5'd0 && src_b == slot_dest[k]))) begin
                    hazard = 1'b1;
                end
            end
        end else begin
            if (slot_valid[0] && slot_load[0] &&
                ((src_a != 5'd0 && src_a == slot_dest[0]) ||
                 (src_b != 5'd0 && src_b == slot_dest[0]))) begin
                hazard = 1'b1;
            end
        end
    end

    assign stall   = issue_valid & (hazard | (shadow_cnt != 3'd0));
    assign accept  = issue_valid & ~stall;
    assign illegal = issue_valid & dec_illegal;

    // The slot pipeline keeps shifting while issue is stalled. Stalled
    // producers therefore drain out and a stall can never become permanent.
    // A new entry is written only for an accepted instruction with a
    // non-zero destination. Otherwise a bubble enters slot 0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_valid <= '0;
            slot_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_dest[k] <= 5'd0;
            end
            shadow_cnt <= 3'd0;
            wb_valid   <= 1'b0;
            wb_dest    <= 5'd0;
        end else begin
            wb_valid <= slot_valid[DEPTH-1];
            wb_dest  <= slot_valid[DEPTH-1] ? slot_dest[DEPTH-1] : 5'd0;
            for (int k = DEPTH - 1; k > 0; k--) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_load[k]  <= slot_load[k-1];
                slot_dest[k]  <= slot_dest[k-1];
            end
            slot_valid[0] <= accept && (dec_dest != 5'd0);
            slot_load[0]  <= dec_load;
            slot_dest[0]  <= dec_dest;
            if (accept && dec_branch) begin
                shadow_cnt <= SHADOW_LOAD;
            end else if (shadow_cnt != 3'd0) begin
                shadow_cnt <= shadow_cnt - 3'd1;
            end
        end
    end

    // Occupancy views. These are derived only from the slot flops, so they
    // show the contents left by the most recent edge.
    always_comb begin
        busy_mask = 32'd0;
        inflight  = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k]) begin
                busy_mask[slot_dest[k]] = 1'b1;
                inflight = inflight + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_dest_scoreboard.sv
// tb_dest_scoreboard
// Drives two scoreboard instances with the same issue stream:
//   dut0: DEPTH=3, FWD=0, BR_SHADOW=2
//   dut1: DEPTH=4, FWD=1, BR_SHADOW=0
// The reference model keeps a per-cycle history of accepted destinations.
// A slot k in cycle t holds whatever was accepted in cycle t-1-k, unless a
// flush or reset has happened since then.

module tb_dest_scoreboard;

    localparam int NCYC = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic [31:0] issue_instr;

    logic        stall_w  [2];
    logic        accept_w [2];
    logic [31:0] busy_w   [2];
    logic [3:0]  infl_w   [2];
    logic        wbv_w    [2];
    logic [4:0]  wbd_w    [2];
    logic        ill_w    [2];

    int vecCount  = 0;
    int missCount = 0;
    int cyc       = 0;

    int pDepth [2] = '{3, 4};
    int pFwd   [2] = '{0, 1};
    int pShad  [2] = '{2, 0};

    int hDest     [2][NCYC];
    bit hLoad     [2][NCYC];
    int lastFlush [2] = '{-1, -1};
    int lastBr    [2] = '{-100, -100};

    bit          obsAcc [2];
    logic [31:0] obsBusy0;

    always #5 clk = ~clk;

    dest_scoreboard #(.DEPTH(3), .FWD(0), .BR_SHADOW(2)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .stall(stall_w[0]), .accept(accept_w[0]), .busy_mask(busy_w[0]),
        .inflight(infl_w[0]), .wb_valid(wbv_w[0]), .wb_dest(wbd_w[0]),
        .illegal(ill_w[0])
    );

    dest_scoreboard #(.DEPTH(4), .FWD(1), .BR_SHADOW(0)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .stall(stall_w[1]), .accept(accept_w[1]), .busy_mask(busy_w[1]),
        .inflight(infl_w[1]), .wb_valid(wbv_w[1]), .wb_dest(wbd_w[1]),
        .illegal(ill_w[1])
    );

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Instruction meaning from the opcode table; unused sources read as 0.
    task automatic decodeRef(input logic [31:0] ins, output int dest, output int s1,
                             output int s2, output bit ld, output bit br, output bit ill);
        int rsf = int'(ins[25:21]);
        int rtf = int'(ins[20:16]);
        int rdf = int'(ins[15:11]);
        dest = 0; s1 = 0; s2 = 0; ld = 0; br = 0; ill = 0;
        case (int'(ins[31:26]))
            0:       begin dest = rdf; s1 = rsf; s2 = rtf; end
            8:       begin dest = rtf; s1 = rsf; end
            35:      begin dest = rtf; s1 = rsf; ld = 1; end
            43:      begin s1 = rsf; s2 = rtf; end
            2:       begin br = 1; end
            4:       begin s1 = rsf; s2 = rtf; br = 1; end
            default: begin ill = 1; end
        endcase
    endtask

    // One clock cycle. Inputs are driven after the falling edge and outputs
    // are checked just before the rising edge. The model history is then
    // extended with this cycle.
    task automatic applyStimulus(input bit v, input logic [31:0] ins, input bit fl,
                                 input bit rst, input bit chk);
        int dest, s1, s2, a, cnt;
        bit ld, br, ill, haz, shad, eStall, eAcc, eWbv;
        logic [31:0] eBusy;
        int eWbd;
        @(negedge clk);
        issue_valid = v;
        issue_instr = ins;
        flush       = fl;
        reset       = rst;
        #1;
        decodeRef(ins, dest, s1, s2, ld, br, ill);
        obsBusy0 = busy_w[0];
        for (int i = 0; i < 2; i++) begin
            eBusy = 32'd0;
            cnt   = 0;
            haz   = 0;
            for (int k = 0; k < pDepth[i]; k++) begin
                a = cyc - 1 - k;
                if (a >= 0 && a > lastFlush[i] && hDest[i][a] != 0) begin
                    eBusy[hDest[i][a]] = 1'b1;
                    cnt++;
                    if ((pFwd[i] == 0 || (k == 0 && hLoad[i][a])) &&
                        ((s1 != 0 && s1 == hDest[i][a]) || (s2 != 0 && s2 == hDest[i][a])))
                        haz = 1;
                end
            end
            a = cyc - 1 - pDepth[i];
            eWbv = (a >= 0 && a > lastFlush[i] && hDest[i][a] != 0);
            eWbd = eWbv ? hDest[i][a] : 0;
            shad = (lastBr[i] > lastFlush[i]) && (cyc - lastBr[i] <= pShad[i]);
            eStall = v && (haz || shad);
            eAcc   = v && !eStall;
            if (chk) begin
                checkOutput($sformatf("d%0d_stall", i), 32'(stall_w[i]), 32'(eStall));
                checkOutput($sformatf("d%0d_accept", i), 32'(accept_w[i]), 32'(eAcc));
                checkOutput($sformatf("d%0d_illegal", i), 32'(ill_w[i]), 32'(v && ill));
                checkOutput($sformatf("d%0d_busy", i), busy_w[i], eBusy);
                checkOutput($sformatf("d%0d_inflight", i), 32'(infl_w[i]), 32'(cnt));
                checkOutput($sformatf("d%0d_wbvalid", i), 32'(wbv_w[i]), 32'(eWbv));
                checkOutput($sformatf("d%0d_wbdest", i), 32'(wbd_w[i]), 32'(eWbd));
            end
            obsAcc[i] = (accept_w[i] === 1'b1);
            if (cyc < NCYC) begin
                if (rst || fl) begin
                    lastFlush[i] = cyc;
                    hDest[i][cyc] = 0;
                    hLoad[i][cyc] = 0;
                end else begin
                    hDest[i][cyc] = eAcc ? dest : 0;
                    hLoad[i][cyc] = ld;
                    if (eAcc && br) lastBr[i] = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Offers ins every cycle until both instances accept it, within a
    // bound, and returns the number of stalled cycles seen by each.
    task automatic holdUntilAccept(input logic [31:0] ins, output int n0, output int n1);
        bit done0 = 0;
        bit done1 = 0;
        n0 = 0;
        n1 = 0;
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b1, ins, 1'b0, 1'b0, 1'b1);
            if (!done0) begin if (obsAcc[0]) done0 = 1; else n0++; end
            if (!done1) begin if (obsAcc[1]) done1 = 1; else n1++; end
            if (done0 && done1) break;
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ins = $urandom;
        int sel = $urandom_range(0, 7);
        case (sel)
            0:       ins[31:26] = 6'b000000;
            1, 7:    ins[31:26] = 6'b001000;
            2:       ins[31:26] = 6'b100011;
            3:       ins[31:26] = 6'b101011;
            4:       ins[31:26] = 6'b000010;
            5:       ins[31:26] = 6'b000100;
            default: ins[31:26] = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h0F;
        endcase
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        int n0, n1;
        reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_instr = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h20080005, 1'b0, 1'b1, 1'b1);
        idle(3);

        // RAW on addi result: dut0 waits for the producer to drain, dut1 forwards
        applyStimulus(1'b1, 32'h20080005, 1'b0, 1'b0, 1'b1);
        holdUntilAccept(32'h01084820, n0, n1);
        checkOutput("raw_stalls_nofwd", 32'(n0), 32'd3);
        checkOutput("raw_stalls_fwd", 32'(n1), 32'd0);
        idle(6);

        // Load-use: one bubble with forwarding
        applyStimulus(1'b1, 32'h8C880000, 1'b0, 1'b0, 1'b1);
        holdUntilAccept(32'h01084820, n0, n1);
        checkOutput("lw_stalls_nofwd", 32'(n0), 32'd3);
        checkOutput("lw_stalls_fwd", 32'(n1), 32'd1);
        idle(6);

        // Branch shadow: two cycles on dut0, none on dut1
        applyStimulus(1'b1, 32'h11090003, 1'b0, 1'b0, 1'b1);
        holdUntilAccept(32'h200A0001, n0, n1);
        checkOutput("shadow_stalls_2", 32'(n0), 32'd2);
        checkOutput("shadow_stalls_0", 32'(n1), 32'd0);
        idle(6);

        // $0 writes and stores leave no entry; reads of $0 never stall
        applyStimulus(1'b1, 32'h20000001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hAC880000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00004820, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Illegal opcode is accepted with no entry
        applyStimulus(1'b1, 32'hFC000000, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Flush with $8 and $9 in flight, offering a branch that is discarded
        applyStimulus(1'b1, 32'h20080005, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h20090005, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h11090003, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_pre_busy", obsBusy0, 32'h300);
        applyStimulus(1'b1, 32'h01084820, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Randomized traffic with occasional flush and reset
        for (int j = 0; j < 800; j++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(),
                          $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0, 1'b1);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
